// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and latch control outputs between pipeline and hazard controller
interface pipeline_hazard_ctrl_if #(
  parameter int REGW = 5
);
  logic            ihit;
  logic            dhit;
  logic            mem_dreq;
  logic            ex_memread;
  logic [REGW-1:0] ex_rd;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_uses_rt;
  logic            branch_taken;
  logic            halt_in;

  logic            pc_en;
  logic            if_id_stall;
  logic            id_ex_stall;
  logic            ex_mem_stall;
  logic            mem_wb_stall;
  logic            if_id_bubble;
  logic            id_ex_bubble;
  logic            ex_mem_bubble;
  logic            mem_wb_bubble;
  logic            halted;

  modport master (
    output ihit, dhit, mem_dreq, ex_memread, ex_rd, id_rs, id_rt, id_uses_rt, branch_taken, halt_in,
    input  pc_en, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, halted
  );

  modport slave (
    input  ihit, dhit, mem_dreq, ex_memread, ex_rd, id_rs, id_rt, id_uses_rt, branch_taken, halt_in,
    output pc_en, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble, halted
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush/halt controller
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_count counters.
module pipeline_hazard_ctrl #(
  parameter int LU_CYCLES = 1,
  parameter int REGW      = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  pipeline_hazard_ctrl_if.slave    hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [15:0]              flush_count
`endif
);

  typedef enum logic [1:0] {RUN, LDUSE, DWAIT, HALT} state_t;

  state_t     state, next_state;
  logic [1:0] lu_cnt, lu_next;
  logic       lu;
  logic       flush;
  logic       pc_en;
  logic [3:0] stall;   // {if_id, id_ex, ex_mem, mem_wb}
  logic [3:0] bubble;  // {if_id, id_ex, ex_mem, mem_wb}
  logic       halted;

  assign lu = hz.ex_memread && (hz.ex_rd != REGW'(0)) &&
              ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      lu_cnt <= 2'd0;
    end else begin
      state  <= next_state;
      lu_cnt <= lu_next;
    end
  end

  always_comb begin
    pc_en      = 1'b1;
    stall      = 4'b0000;
    bubble     = 4'b0000;
    halted     = 1'b0;
    flush      = 1'b0;
    next_state = RUN;
    lu_next    = lu_cnt;
    if (RST) begin
      pc_en   = 1'b0;
      bubble  = 4'b1111;
      lu_next = 2'd0;
    end else if (state == HALT || hz.halt_in) begin
      pc_en      = 1'b0;
      stall      = 4'b1111;
      halted     = (state == HALT);
      next_state = HALT;
    end else if (hz.mem_dreq && !hz.dhit) begin
      pc_en      = 1'b0;
      stall      = 4'b1110;
      bubble     = 4'b0001;
      next_state = DWAIT;
      lu_next    = 2'd0;
    end else if (hz.branch_taken) begin
      // A branch held in EX through a data wait lands here on the dhit cycle.
      bubble  = 4'b1100;
      flush   = 1'b1;
      lu_next = 2'd0;
    end else if (state == LDUSE || lu) begin
      // Load-use stall also covers a concurrent fetch wait: IF/ID holds, no bubble.
      pc_en  = 1'b0;
      stall  = 4'b1000;
      bubble = 4'b0100;
      if (state == LDUSE) begin
        lu_next    = lu_cnt - 2'd1;
        next_state = (lu_cnt == 2'd1) ? RUN : LDUSE;
      end else if (LU_CYCLES > 1) begin
        lu_next    = 2'(LU_CYCLES - 1);
        next_state = LDUSE;
      end
    end else if (!hz.ihit) begin
      pc_en  = 1'b0;
      bubble = 4'b1000;
    end
  end

  assign hz.pc_en         = pc_en;
  assign hz.if_id_stall   = stall[3];
  assign hz.id_ex_stall   = stall[2];
  assign hz.ex_mem_stall  = stall[1];
  assign hz.mem_wb_stall  = stall[0];
  assign hz.if_id_bubble  = bubble[3];
  assign hz.id_ex_bubble  = bubble[2];
  assign hz.ex_mem_bubble = bubble[1];
  assign hz.mem_wb_bubble = bubble[0];
  assign hz.halted        = halted;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if (!pc_en && state != HALT && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized bench for pipeline_hazard_ctrl (LU_CYCLES 2 and 4)
module tb_pipeline_hazard_ctrl;
  localparam int REGW = 5;

  // {pc_en, stall if_id/id_ex/ex_mem/mem_wb, bubble if_id/id_ex/ex_mem/mem_wb, halted}
  localparam logic [9:0] O_IDLE   = 10'b1_0000_0000_0;
  localparam logic [9:0] O_RST    = 10'b0_0000_1111_0;
  localparam logic [9:0] O_LU     = 10'b0_1000_0100_0;
  localparam logic [9:0] O_DW     = 10'b0_1110_0001_0;
  localparam logic [9:0] O_BR     = 10'b1_0000_1100_0;
  localparam logic [9:0] O_FW     = 10'b0_0000_1000_0;
  localparam logic [9:0] O_HALTIN = 10'b0_1111_0000_0;
  localparam logic [9:0] O_HALTED = 10'b0_1111_0000_1;

  logic CLK = 1'b0;
  logic RST;
  logic ihit, dhit, mem_dreq, ex_memread, id_uses_rt, branch_taken, halt_in;
  logic [REGW-1:0] ex_rd, id_rs, id_rt;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl_if #(.REGW(REGW)) ifa ();
  pipeline_hazard_ctrl_if #(.REGW(REGW)) ifb ();

  assign ifa.ihit = ihit;             assign ifb.ihit = ihit;
  assign ifa.dhit = dhit;             assign ifb.dhit = dhit;
  assign ifa.mem_dreq = mem_dreq;     assign ifb.mem_dreq = mem_dreq;
  assign ifa.ex_memread = ex_memread; assign ifb.ex_memread = ex_memread;
  assign ifa.ex_rd = ex_rd;           assign ifb.ex_rd = ex_rd;
  assign ifa.id_rs = id_rs;           assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;           assign ifb.id_rt = id_rt;
  assign ifa.id_uses_rt = id_uses_rt; assign ifb.id_uses_rt = id_uses_rt;
  assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;
  assign ifa.halt_in = halt_in;       assign ifb.halt_in = halt_in;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_a, stall_cycles_b;
  logic [15:0] flush_count_a, flush_count_b;
  pipeline_hazard_ctrl #(.LU_CYCLES(2), .REGW(REGW)) dut_a (.CLK(CLK), .RST(RST), .hz(ifa),
    .stall_cycles(stall_cycles_a), .flush_count(flush_count_a));
  pipeline_hazard_ctrl #(.LU_CYCLES(4), .REGW(REGW)) dut_b (.CLK(CLK), .RST(RST), .hz(ifb),
    .stall_cycles(stall_cycles_b), .flush_count(flush_count_b));
`else
  pipeline_hazard_ctrl #(.LU_CYCLES(2), .REGW(REGW)) dut_a (.CLK(CLK), .RST(RST), .hz(ifa));
  pipeline_hazard_ctrl #(.LU_CYCLES(4), .REGW(REGW)) dut_b (.CLK(CLK), .RST(RST), .hz(ifb));
`endif

  logic [9:0] oa, ob;
  assign oa = {ifa.pc_en, ifa.if_id_stall, ifa.id_ex_stall, ifa.ex_mem_stall, ifa.mem_wb_stall,
               ifa.if_id_bubble, ifa.id_ex_bubble, ifa.ex_mem_bubble, ifa.mem_wb_bubble, ifa.halted};
  assign ob = {ifb.pc_en, ifb.if_id_stall, ifb.id_ex_stall, ifb.ex_mem_stall, ifb.mem_wb_stall,
               ifb.if_id_bubble, ifb.id_ex_bubble, ifb.ex_mem_bubble, ifb.mem_wb_bubble, ifb.halted};

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b1; mem_dreq = 1'b0; ex_memread = 1'b0; id_uses_rt = 1'b0;
    branch_taken = 1'b0; halt_in = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
  endtask

  task automatic set_lu(input logic [REGW-1:0] rd);
    ex_memread = 1'b1; ex_rd = rd; id_rs = rd;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (oa !== O_RST) begin errors++; $display("FAIL reset_a got=%b exp=%b", oa, O_RST); end
    checks++; if (ob !== O_RST) begin errors++; $display("FAIL reset_b got=%b exp=%b", ob, O_RST); end
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (oa !== O_IDLE) begin errors++; $display("FAIL idle_a got=%b exp=%b", oa, O_IDLE); end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5'd5);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++; if (oa !== O_LU) begin errors++; $display("FAIL lu2_c%0d got=%b exp=%b", c, oa, O_LU); end
      next_cycle();
    end
    idle_inputs();
    for (int c = 2; c < 5; c++) begin
      @(negedge CLK);
      checks++; if (oa !== O_IDLE) begin errors++; $display("FAIL lu2_after_c%0d got=%b exp=%b", c, oa, O_IDLE); end
      checks++;
      if (ob !== ((c < 4) ? O_LU : O_IDLE)) begin
        errors++; $display("FAIL lu4_c%0d got=%b exp=%b", c, ob, (c < 4) ? O_LU : O_IDLE);
      end
      next_cycle();
    end
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    @(negedge CLK);
    checks++; if (oa !== O_IDLE) begin errors++; $display("FAIL lu_rd0 got=%b exp=%b", oa, O_IDLE); end
    ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
    @(negedge CLK);
    checks++; if (oa !== O_IDLE) begin errors++; $display("FAIL lu_rt_unused got=%b exp=%b", oa, O_IDLE); end
    id_uses_rt = 1'b1;
    @(negedge CLK);
    checks++; if (oa !== O_LU) begin errors++; $display("FAIL lu_rt_used got=%b exp=%b", oa, O_LU); end
    next_cycle();
  endtask

  task automatic test_dwait();
    do_reset();
    mem_dreq = 1'b1; dhit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++; if (oa !== O_DW) begin errors++; $display("FAIL dwait_c%0d got=%b exp=%b", c, oa, O_DW); end
      next_cycle();
    end
    dhit = 1'b1;
    @(negedge CLK);
    checks++; if (oa !== O_IDLE) begin errors++; $display("FAIL dwait_dhit got=%b exp=%b", oa, O_IDLE); end
    next_cycle();
    dhit = 1'b0; branch_taken = 1'b1;
    @(negedge CLK);
    checks++; if (oa !== O_DW) begin errors++; $display("FAIL dwait_branch_held got=%b exp=%b", oa, O_DW); end
    next_cycle();
    dhit = 1'b1;
    @(negedge CLK);
    checks++; if (oa !== O_BR) begin errors++; $display("FAIL dwait_branch_act got=%b exp=%b", oa, O_BR); end
    next_cycle();
  endtask

  task automatic test_branch_lu();
    do_reset();
    set_lu(5'd5); branch_taken = 1'b1;
    @(negedge CLK);
    checks++; if (ob !== O_BR) begin errors++; $display("FAIL br_lu got=%b exp=%b", ob, O_BR); end
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    checks++; if (ob !== O_IDLE) begin errors++; $display("FAIL br_no_lduse got=%b exp=%b", ob, O_IDLE); end
    next_cycle();
  endtask

  task automatic test_fetch_wait();
    do_reset();
    ihit = 1'b0;
    @(negedge CLK);
    checks++; if (oa !== O_FW) begin errors++; $display("FAIL fetch_wait got=%b exp=%b", oa, O_FW); end
    set_lu(5'd9);
    @(negedge CLK);
    checks++; if (oa !== O_LU) begin errors++; $display("FAIL fetch_wait_lu got=%b exp=%b", oa, O_LU); end
    next_cycle();
  endtask

  task automatic test_halt();
    do_reset();
    halt_in = 1'b1;
    @(negedge CLK);
    checks++; if (oa !== O_HALTIN) begin errors++; $display("FAIL halt_in got=%b exp=%b", oa, O_HALTIN); end
    next_cycle();
    for (int c = 0; c < 10; c++) begin
      {ihit, dhit, mem_dreq, ex_memread, id_uses_rt, branch_taken, halt_in} = 7'($urandom);
      ex_rd = 5'($urandom); id_rs = ex_rd; id_rt = 5'($urandom);
      @(negedge CLK);
      checks++; if (oa !== O_HALTED) begin errors++; $display("FAIL halted_c%0d got=%b exp=%b", c, oa, O_HALTED); end
      next_cycle();
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (oa !== O_RST) begin errors++; $display("FAIL halt_rst got=%b exp=%b", oa, O_RST); end
    next_cycle();
    RST = 1'b0; idle_inputs();
    @(negedge CLK);
    checks++; if (oa !== O_IDLE) begin errors++; $display("FAIL halt_exit got=%b exp=%b", oa, O_IDLE); end
    next_cycle();
  endtask

  task automatic test_reset_mid_lduse();
    do_reset();
    set_lu(5'd5);
    next_cycle();
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (ob !== O_RST) begin errors++; $display("FAIL rst_lduse got=%b exp=%b", ob, O_RST); end
    next_cycle();
    RST = 1'b0; idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++; if (ob !== O_IDLE) begin errors++; $display("FAIL rst_lduse_after_c%0d got=%b exp=%b", c, ob, O_IDLE); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    bit halted_m[2];
    int lu_left[2];
    logic [9:0] exp, got;
    bit lu;
    do_reset();
    halted_m = '{0, 0};
    lu_left = '{0, 0};
    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom % 64) == 0;
      halt_in = ($urandom % 300) == 0;
      ihit = ($urandom % 4) != 0;
      mem_dreq = ($urandom % 3) == 0;
      dhit = ($urandom % 2) == 0;
      ex_memread = ($urandom % 2) == 0;
      id_uses_rt = ($urandom % 2) == 0;
      branch_taken = ($urandom % 6) == 0;
      ex_rd = 5'($urandom % 4); id_rs = 5'($urandom % 4); id_rt = 5'($urandom % 4);
      lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        int lu_cycles;
        lu_cycles = (k == 0) ? 2 : 4;
        exp = O_IDLE;
        if (RST) begin
          exp = O_RST; halted_m[k] = 0; lu_left[k] = 0;
        end else if (halted_m[k] || halt_in) begin
          exp = halted_m[k] ? O_HALTED : O_HALTIN; halted_m[k] = 1;
        end else if (mem_dreq && !dhit) begin
          exp = O_DW; lu_left[k] = 0;
        end else if (branch_taken) begin
          exp = O_BR; lu_left[k] = 0;
        end else if (lu_left[k] > 0 || lu) begin
          exp = O_LU;
          lu_left[k] = (lu_left[k] > 0) ? lu_left[k] - 1 : lu_cycles - 1;
        end else if (!ihit) begin
          exp = O_FW;
        end
        got = (k == 0) ? oa : ob;
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL random_%0d cycle=%0d got=%b exp=%b", k, n, got, exp);
        end
      end
      next_cycle();
    end
    RST = 1'b0;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    do_reset();
    ihit = 1'b0;
    repeat (5) next_cycle();
    ihit = 1'b1; branch_taken = 1'b1;
    repeat (2) next_cycle();
    idle_inputs();
    @(negedge CLK);
    checks++; if (stall_cycles_a !== 32'd5) begin errors++; $display("FAIL perf_stall got=%0d exp=5", stall_cycles_a); end
    checks++; if (flush_count_a !== 16'd2) begin errors++; $display("FAIL perf_flush got=%0d exp=2", flush_count_a); end
    branch_taken = 1'b1;
    repeat (65540) next_cycle();
    @(negedge CLK);
    checks++; if (flush_count_a !== 16'hFFFF) begin errors++; $display("FAIL perf_flush_sat got=%h exp=ffff", flush_count_a); end
    next_cycle();
    do_reset();
    @(negedge CLK);
    checks++; if (stall_cycles_a !== 32'd0) begin errors++; $display("FAIL perf_reset got=%0d exp=0", stall_cycles_a); end
    next_cycle();
  endtask
`endif

  initial begin
    idle_inputs();
    RST = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_dwait();
    test_branch_lu();
    test_fetch_wait();
    test_halt();
    test_reset_mid_lduse();
    test_random();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: LU_CYCLES, default 1, load-use stall length in cycles, legal range 1..4; REGW, default 5, register index width.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  clock; all state updates on posedge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 ihit  in  1  instruction memory has valid data this cycle.
REQ-006 dhit  in  1  data memory completes the MEM-stage access this cycle.
REQ-007 mem_dreq  in  1  MEM stage holds a load or store.
REQ-008 ex_memread  in  1  EX stage holds a load.
REQ-009 ex_rd  in  REGW  destination register of the EX-stage instruction.
REQ-010 id_rs, id_rt  in  REGW each  source registers of the ID-stage instruction.
REQ-011 id_uses_rt  in  1  ID-stage instruction reads rt.
REQ-012 branch_taken  in  1  EX stage resolved a taken branch or jump.
REQ-013 halt_in  in  1  halt instruction reached MEM/WB.
REQ-014 pc_en  out  1  PC update enable.
REQ-015 {if_id,id_ex,ex_mem,mem_wb}_stall  out  1 each  hold the latch contents.
REQ-016 {if_id,id_ex,ex_mem,mem_wb}_bubble  out  1 each  load zeros into the latch; bubble overrides stall in the latch.
REQ-017 halted  out  1  core is halted.

Function
REQ-018 State SHALL be one of RUN, LDUSE, DWAIT, HALT, plus a 2-bit load-use counter lu_cnt.
REQ-019 Load-use hazard (lu) SHALL be: ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
REQ-020 Default outputs SHALL be: pc_en=1, all stalls 0, all bubbles 0, halted=0.
REQ-021 Per-cycle priority SHALL be HALT state > halt_in > data wait > branch flush > load-use > fetch wait.
REQ-022 HALT state or halt_in SHALL drive pc_en=0, all four stalls 1, all bubbles 0, and next state HALT; halted=1 only in HALT state; HALT exits only on RST.
REQ-023 Data wait (mem_dreq & ~dhit) SHALL drive pc_en=0, if_id/id_ex/ex_mem stall=1, mem_wb_bubble=1, and next state DWAIT.
REQ-024 DWAIT SHALL return to RUN on the cycle dhit=1; that cycle uses the normal rules below.
REQ-025 Branch flush (branch_taken) SHALL drive pc_en=1, if_id_bubble=1, id_ex_bubble=1, and next state RUN; it SHALL cancel any pending LDUSE and clear lu_cnt.
REQ-026 A branch asserted during a data wait SHALL be held by the stalled EX stage and acted on in the first cycle with dhit=1.
REQ-027 Load-use in RUN SHALL drive pc_en=0, if_id_stall=1, id_ex_bubble=1; if LU_CYCLES>1, next state LDUSE with lu_cnt=LU_CYCLES-1, else RUN.
REQ-028 LDUSE SHALL repeat the REQ-027 outputs, decrement lu_cnt each cycle, and return to RUN after the cycle in which lu_cnt=1; total stall is exactly LU_CYCLES cycles.
REQ-029 Fetch wait (~ihit, no higher event) SHALL drive pc_en=0 and if_id_bubble=1; a simultaneous load-use SHALL instead keep if_id_stall=1 and suppress if_id_bubble.
REQ-030 All outputs SHALL be combinational from state and current inputs; no latency beyond that.

Reset
REQ-031 While RST=1, outputs SHALL be pc_en=0, all stalls 0, all four bubbles 1, halted=0.
REQ-032 RST at a clock edge SHALL force state RUN and lu_cnt=0 from any state, including mid-LDUSE, DWAIT or HALT.

Configuration
REQ-033 With HAZARD_PERF_EN defined, outputs stall_cycles[31:0] and flush_count[15:0] SHALL exist, reset to 0 on RST, saturate at all-ones, and increment on cycles with pc_en=0 outside HALT and on each branch flush cycle respectively.
REQ-034 Without HAZARD_PERF_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-035 ex_memread=1, ex_rd=5, id_rs=5, LU_CYCLES=2 -> pc_en=0, if_id_stall=1, id_ex_bubble=1 for exactly 2 cycles, then RUN.
REQ-036 mem_dreq=1, dhit=0 for 3 cycles, then 1 -> 3 cycles pc_en=0, ex_mem_stall=1, mem_wb_bubble=1; normal flow on the dhit cycle.
REQ-037 branch_taken=1 together with a load-use -> if_id_bubble=1, id_ex_bubble=1, pc_en=1, no LDUSE entry.
REQ-038 halt_in=1 -> halted=1 next cycle and stays 1 for 10 cycles despite all inputs toggling; RST=1 -> halted=0, state RUN.
REQ-039 RST asserted in the 1st cycle of a 4-cycle LDUSE -> after reset, no further stall cycles; ex_rd=0 with ex_memread=1 -> no stall.
REQ-040 HAZARD_PERF_EN: 5 stall cycles and 2 flushes -> stall_cycles=5, flush_count=2; preload near all-ones -> saturates.
